grid_dump: RTL and testbench
============================

Name: grid_dump

Overview:
- Solution read-out unit attached to the tile network's row-major one-hot value bus.
- On a host request it waits for the grid solver to finish, then snapshots all tile values.
- Streams the values out serially, one tile per beat in row-major order, over a valid/ready interface.
- Tile values are converted from one-hot to binary digits, so the host never has to decode one-hot.

Parameters:
- ORD, 3, grid order. LEN = ORD*ORD and AREA = LEN*LEN are derived localparams; ORD 2..4 is supported.
- DW, $clog2(LEN+1), width of out_data when GRID_DUMP_ASCII_EN is undefined.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  host request pulse; honoured only in IDLE.
- grid_done  in  1  solver finished (level).
- grid_success  in  1  solver found a solution; valid while grid_done=1.
- values  in  AREA*LEN  row-major one-hot tile values; tile i = r*LEN+c occupies bits [i*LEN +: LEN].
- busy  out  1  high in any state other than IDLE.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DW (8 with ASCII)  decoded tile value.
- out_row  out  $clog2(LEN)  row of the current beat.
- out_col  out  $clog2(LEN)  column of the current beat.
- out_last  out  1  high on the beat for tile AREA-1.
- out_bad  out  1  current tile is not one-hot and not zero.
- fail  out  1  one-cycle pulse when the solver reported failure.
- finished  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs are 0; the index, row and column counters are 0; the snapshot register is 0.
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - start=1 -> WAIT on the next edge.
  - start in any other state is ignored. No queuing.
- WAIT:
  - grid_done=1 and grid_success=1 -> load the snapshot from values, zero the index/row/col counters, go to SEND.
  - grid_done=1 and grid_success=0 -> fail pulses for 1 cycle, go to IDLE. No beats are sent.
  - grid_done=0 -> stay in WAIT indefinitely.
- SEND:
  - out_valid=1 continuously.
  - out_data, out_row, out_col, out_last and out_bad come from registered snapshot and counters. Their decode is combinational from registers, so they are stable while stalled.
  - Beat transfers when out_valid and out_ready are both 1 at a rising edge.
  - On transfer: col increments. If col=LEN-1, col wraps to 0 and row increments. The index increments as well.
  - Transfer with out_last=1 -> finished pulses for 1 cycle, out_valid=0, go to IDLE.
  - First beat is available the cycle after leaving WAIT (latency 1 from grid_done, sampled high).
  - Full throughput: with out_ready held at 1, AREA beats arrive in AREA consecutive cycles.
- Decode:
  - one-hot bit k set -> out_data = k+1.
  - all-zero -> 0 (empty tile), out_bad=0.
  - more than one bit set -> out_data = index of the lowest set bit + 1, out_bad=1.
- The snapshot is taken once. Changes on values during SEND are not visible on the output.
- out_ready is ignored outside SEND. out_valid never drops in SEND without a transfer.
- Reset asserted mid-stream: immediate return to IDLE with outputs cleared. A partial stream is not resumed.
- A finished or fail pulse coincides with busy falling, measured on the next cycle. start on that same cycle, after IDLE is reached, is honoured.

Optional Feature:
- GRID_DUMP_ASCII_EN defined: out_data is 8 bits of ASCII.
  - Digits 1..9 -> "1".."9".
  - Digits 10..16 -> "A".."G".
  - Empty -> ".".
  - Malformed tiles use the same lowest-bit rule, encoded in ASCII.
- GRID_DUMP_ASCII_EN undefined: out_data is the DW-bit binary digit described above.
- Handshake, ordering and timing are identical in both builds.

Test Plan:
- Normal dump (ORD=3): start, then grid_done=1, grid_success=1 after 10 cycles, out_ready=1, valid 9x9 solution. Required: 81 beats on consecutive cycles. Beat 0 has row 0, col 0. Beat 9 has row 1, col 0. Beat 80 has out_last=1. finished pulses once. Data matches the decoded solution.
- Back-pressure: out_ready toggled 1,0,0,1 repeatedly. Required: outputs hold stable while out_ready=0, no beat is duplicated or dropped, and the total is 81 transfers.
- Failure path: start, then grid_done=1, grid_success=0. Required: fail is high for exactly 1 cycle, out_valid stays 0, busy falls, state returns to IDLE.
- Decode edges: tile 0 = 9'b0 -> data 0, bad=0. Tile 1 = 9'b1_0000_0000 -> data 9. Tile 2 = 9'b000_000_110 -> data 2, bad=1. values changed mid-stream -> output is unchanged.
- Reset mid-stream: reset=0 at beat 40 -> out_valid=0 immediately (asynchronous). After release, start restarts the stream at row 0, col 0.
- ASCII build (GRID_DUMP_ASCII_EN): digit 5 -> 8'h35. Empty -> 8'h2E. ORD=4 digit 12 -> 8'h43 ("C").

Source files
------------

// File: rtl/grid_dump.sv
// rtl/grid_dump.sv - snapshots solved tile values and streams them out one tile per beat (GRID_DUMP_ASCII_EN selects ASCII out_data)
module grid_dump #(
    parameter int ORD = 3,
    parameter int DW  = $clog2(ORD*ORD+1)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              grid_done,
    input  logic                              grid_success,
    input  logic [ORD*ORD*ORD*ORD*ORD*ORD-1:0] values,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
`ifdef GRID_DUMP_ASCII_EN
    output logic [7:0]                        out_data,
`else
    output logic [DW-1:0]                     out_data,
`endif
    output logic [$clog2(ORD*ORD)-1:0]        out_row,
    output logic [$clog2(ORD*ORD)-1:0]        out_col,
    output logic                              out_last,
    output logic                              out_bad,
    output logic                              fail,
    output logic                              finished
);

    localparam int LEN  = ORD*ORD;
    localparam int AREA = LEN*LEN;
    localparam int CW   = $clog2(LEN);
    localparam int IW   = $clog2(AREA);
    localparam logic [CW-1:0] COL_MAX = CW'(LEN-1);
    localparam logic [IW-1:0] IDX_MAX = IW'(AREA-1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

    state_t              state, state_next;
    logic [AREA*LEN-1:0] snap;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       row, col;
    logic                fail_q, finished_q;
    logic                load, fail_set, xfer, last;
    logic [LEN-1:0]      tile;
    logic [DW-1:0]       digit;
    logic                multi;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        fail_set   = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_WAIT;
            S_WAIT: begin
                if (grid_done) begin
                    if (grid_success) begin
                        load       = 1'b1;
                        state_next = S_SEND;
                    end else begin
                        fail_set   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_SEND: if (out_ready && last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign xfer = (state == S_SEND) && out_ready;
    assign last = (idx == IDX_MAX);

    // Counters return to zero after the final beat so the next dump starts clean.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap       <= '0;
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            fail_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            fail_q     <= fail_set;
            finished_q <= xfer && last;
            if (load) begin
                snap <= values;
                idx  <= '0;
                row  <= '0;
                col  <= '0;
            end else if (xfer) begin
                if (last) begin
                    idx <= '0;
                    row <= '0;
                    col <= '0;
                end else begin
                    idx <= idx + 1'b1;
                    if (col == COL_MAX) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

    assign tile  = snap[idx*LEN +: LEN];
    assign multi = |(tile & (tile - LEN'(1)));

    // Scanning downward lets the lowest set bit win on malformed tiles.
    always_comb begin
        digit = '0;
        for (int k = LEN-1; k >= 0; k--) begin
            if (tile[k]) digit = DW'(k+1);
        end
    end

`ifdef GRID_DUMP_ASCII_EN
    logic [7:0] ascii;
    always_comb begin
        ascii = 8'h2E;
        if (digit == '0)           ascii = 8'h2E;
        else if (digit <= DW'(9))  ascii = 8'h30 + 8'(digit);
        else                       ascii = 8'h37 + 8'(digit);
    end
    assign out_data = out_valid ? ascii : 8'h00;
`else
    assign out_data = out_valid ? digit : '0;
`endif

    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_SEND);
    assign out_row   = out_valid ? row : '0;
    assign out_col   = out_valid ? col : '0;
    assign out_last  = out_valid && last;
    assign out_bad   = out_valid && multi;
    assign fail      = fail_q;
    assign finished  = finished_q;

endmodule

// File: tb/tb_grid_dump.sv
// tb/tb_grid_dump.sv - directed table-driven bench for grid_dump (ORD=3)
module tb_grid_dump;

    localparam int ORD  = 3;
    localparam int LEN  = 9;
    localparam int AREA = 81;
    localparam int DW   = 4;
`ifdef GRID_DUMP_ASCII_EN
    localparam int OW = 8;
`else
    localparam int OW = DW;
`endif

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic                grid_done = 1'b0;
    logic                grid_success = 1'b0;
    logic [AREA*LEN-1:0] values = '0;
    logic                busy, out_valid, out_last, out_bad, fail, finished;
    logic                out_ready = 1'b0;
    logic [OW-1:0]       out_data;
    logic [3:0]          out_row, out_col;

    int checks   = 0;
    int failures = 0;

    logic [LEN-1:0] tile_in[AREA];
    int             exp_d[AREA];
    bit             exp_b[AREA];

    typedef struct {
        logic [LEN-1:0] tile;
        int             data;
        bit             bad;
    } vec_t;
    vec_t vecs[7];

    grid_dump #(.ORD(ORD)) dut (
        .clock(clock), .reset(reset), .start(start),
        .grid_done(grid_done), .grid_success(grid_success), .values(values),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .out_bad(out_bad), .fail(fail), .finished(finished)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int enc(input int d);
`ifdef GRID_DUMP_ASCII_EN
        if (d == 0) return 46;
        if (d <= 9) return 48 + d;
        return 55 + d;
`else
        return d;
`endif
    endfunction

    function automatic logic [AREA*LEN-1:0] pack();
        logic [AREA*LEN-1:0] v = '0;
        for (int i = 0; i < AREA; i++) v[i*LEN +: LEN] = tile_in[i];
        return v;
    endfunction

    task automatic load_solution();
        for (int r = 0; r < LEN; r++) begin
            for (int c = 0; c < LEN; c++) begin
                int d = ((r*ORD + r/ORD + c) % LEN) + 1;
                tile_in[r*LEN+c] = LEN'(1) << (d-1);
                exp_d[r*LEN+c]   = d;
                exp_b[r*LEN+c]   = 1'b0;
            end
        end
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1
    task automatic run_dump(input int mode, input bit mutate);
        int  n = 0;
        int  cyc = 0;
        bit  stalled = 0;
        int  s_data = 0, s_row = 0, s_col = 0, s_last = 0, s_bad = 0;
        bit  ready;
        values = pack();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) begin
            step();
        end
        chk("wait_busy", busy, 1);
        chk("wait_valid", out_valid, 0);
        grid_done = 1'b1;
        grid_success = 1'b1;
        step();
        chk("first_beat_latency", out_valid, 1);
        while (n < AREA && cyc < 2000) begin
            ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            out_ready = ready;
            chk("valid_held", out_valid, 1);
            if (stalled) begin
                chk("stall_data", out_data, s_data);
                chk("stall_row", out_row, s_row);
                chk("stall_col", out_col, s_col);
                chk("stall_last", out_last, s_last);
                chk("stall_bad", out_bad, s_bad);
            end
            if (ready) begin
                chk($sformatf("beat%0d_row", n), out_row, n / LEN);
                chk($sformatf("beat%0d_col", n), out_col, n % LEN);
                chk($sformatf("beat%0d_last", n), out_last, n == AREA-1);
                chk($sformatf("beat%0d_data", n), out_data, enc(exp_d[n]));
                chk($sformatf("beat%0d_bad", n), out_bad, exp_b[n]);
                n++;
                stalled = 0;
            end else begin
                s_data = out_data; s_row = out_row; s_col = out_col;
                s_last = out_last; s_bad = out_bad;
                stalled = 1;
            end
            if (mutate && n == 1) values = '1;
            step();
            cyc++;
        end
        out_ready = 1'b0;
        grid_done = 1'b0;
        grid_success = 1'b0;
        chk("beat_total", n, AREA);
        if (mode == 0) chk("consecutive_cycles", cyc, AREA);
        chk("finished_pulse", finished, 1);
        chk("done_busy_low", busy, 0);
        chk("done_valid_low", out_valid, 0);
    endtask

    initial begin
        vecs[0] = '{tile: 9'b0,           data: 0, bad: 1'b0};
        vecs[1] = '{tile: 9'b1_0000_0000, data: 9, bad: 1'b0};
        vecs[2] = '{tile: 9'b000_000_110, data: 2, bad: 1'b1};
        vecs[3] = '{tile: 9'b000_000_001, data: 1, bad: 1'b0};
        vecs[4] = '{tile: 9'b111_111_111, data: 1, bad: 1'b1};
        vecs[5] = '{tile: 9'b110_000_000, data: 8, bad: 1'b1};
        vecs[6] = '{tile: 9'b000_010_000, data: 5, bad: 1'b0};

        repeat (3) begin
            step();
        end
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_fail", fail, 0);
        chk("rst_finished", finished, 0);
        chk("rst_last", out_last, 0);
        reset = 1'b1;
        step();

        load_solution();
        run_dump(0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_on_finish_cycle", busy, 1);
        chk("finished_one_cycle", finished, 0);

        grid_done = 1'b1;
        grid_success = 1'b0;
        step();
        grid_done = 1'b0;
        chk("fail_pulse", fail, 1);
        chk("fail_busy_low", busy, 0);
        chk("fail_no_valid", out_valid, 0);
        step();
        chk("fail_one_cycle", fail, 0);
        chk("fail_idle", busy, 0);
        chk("fail_idle_valid", out_valid, 0);

        run_dump(1, 0);
        step();
        chk("bp_finished_one_cycle", finished, 0);

        for (int i = 0; i < AREA; i++) begin
            tile_in[i] = '0;
            exp_d[i]   = 0;
            exp_b[i]   = 1'b0;
        end
        for (int v = 0; v < 7; v++) begin
            tile_in[v] = vecs[v].tile;
            exp_d[v]   = vecs[v].data;
            exp_b[v]   = vecs[v].bad;
        end
        run_dump(0, 1);
        step();

        load_solution();
        values = pack();
        start = 1'b1;
        step();
        start = 1'b0;
        grid_done = 1'b1;
        grid_success = 1'b1;
        step();
        out_ready = 1'b1;
        begin
            int n = 0;
            int guard = 0;
            while (n < 40 && guard < 200) begin
                if (out_valid) n++;
                step();
                guard++;
            end
            chk("pre_reset_beats", n, 40);
        end
        chk("pre_reset_row", out_row, 4);
        chk("pre_reset_col", out_col, 4);
        reset = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_row", out_row, 0);
        out_ready = 1'b0;
        grid_done = 1'b0;
        grid_success = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("post_reset_idle", busy, 0);
        run_dump(0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
